// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder slice.
//   cla_mode_e     : operation select carried on the bus (ADD / SUB)
//   CLA_*_MIN/MAX  : legal parameter ranges for WIDTH and GROUP
//   cla_num_groups : number of lookahead groups, ceil(width / group)
package cla_pkg;

  typedef enum logic {
    CLA_ADD = 1'b0,
    CLA_SUB = 1'b1
  } cla_mode_e;

  localparam int unsigned CLA_WIDTH_MIN = 2;
  localparam int unsigned CLA_WIDTH_MAX = 64;
  localparam int unsigned CLA_GROUP_MIN = 2;
  localparam int unsigned CLA_GROUP_MAX = 8;

  function automatic int unsigned cla_num_groups(input int unsigned width,
                                                 input int unsigned group);
    return (width + group - 1) / group;
  endfunction

endpackage

// File: rtl/gen_cla_pipelined_if.sv
// Operand/result bus for gen_cla_pipelined.
//   in_valid/in_ready   : operand beat handshake (a, b, cin, mode)
//   out_valid/out_ready : result beat handshake (s, cout, ovf)
// master: the block feeding operands and consuming results.
// slave : the adder itself.
interface gen_cla_pipelined_if
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  cla_mode_e        mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, mode, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, mode, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );

endinterface

// File: rtl/cla_carry_group.sv
// One carry-lookahead group of GROUP bits.
//   g, p   : per-bit generate / propagate (registered upstream)
//   c_in   : carry into the group's lowest bit
//   c      : carry into each bit of the group (c[0] == c_in)
//   grp_g  : group generate, grp_p : group propagate
// All carry terms are flattened AND/OR sums of products so no ripple
// chain forms inside the group.
module cla_carry_group
  import cla_pkg::*;
#(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] g,
  input  logic [GROUP-1:0] p,
  input  logic             c_in,
  output logic [GROUP-1:0] c,
  output logic             grp_g,
  output logic             grp_p
);

  if (GROUP < CLA_GROUP_MIN || GROUP > CLA_GROUP_MAX) begin : g_bad_group
    $error("cla_carry_group: GROUP out of range");
  end

  // Group G/P are kept in their own process so they never depend on c_in;
  // the top-level lookahead feeds c_in from these outputs.
  logic gp_term;
  logic gp_acc;

  always_comb begin
    gp_term = 1'b0;
    gp_acc  = 1'b0;
    for (int unsigned j = 0; j < GROUP; j++) begin
      gp_term = g[j];
      for (int unsigned m = j + 1; m < GROUP; m++) begin
        gp_term = gp_term & p[m];
      end
      gp_acc = gp_acc | gp_term;
    end
    grp_g = gp_acc;
    grp_p = &p;
  end

  // c[k] = c_in&p[0..k-1] | g[0]&p[1..k-1] | ... | g[k-1]
  logic c_term;
  logic c_acc;

  always_comb begin
    c      = '0;
    c_term = 1'b0;
    c_acc  = 1'b0;
    for (int unsigned k = 0; k < GROUP; k++) begin
      c_term = c_in;
      for (int unsigned j = 0; j < k; j++) begin
        c_term = c_term & p[j];
      end
      c_acc = c_term;
      for (int unsigned j = 0; j < k; j++) begin
        c_term = g[j];
        for (int unsigned m = j + 1; m < k; m++) begin
          c_term = c_term & p[m];
        end
        c_acc = c_acc | c_term;
      end
      c[k] = c_acc;
    end
  end

endmodule

// File: rtl/gen_cla_pipelined.sv
// Two-stage pipelined carry-lookahead adder/subtractor.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : operand beat in (a, b, cin, mode; in_valid/in_ready) and
//              result beat out (s, cout, ovf; out_valid/out_ready)
// Stage 1 registers per-bit generate/propagate of a and the effective b
// (inverted for SUB), the effective carry-in and the operand MSBs.
// Stage 2 resolves carries with group lookahead and registers the sum.
// Each stage advances only when the stage after it is empty or draining.
module gen_cla_pipelined
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GROUP = 4
) (
  input  logic                clk,
  input  logic                rst,
  gen_cla_pipelined_if.slave  bus
);

  localparam int unsigned NG = cla_num_groups(WIDTH, GROUP);
  localparam int unsigned PW = NG * GROUP;

  if (WIDTH < CLA_WIDTH_MIN || WIDTH > CLA_WIDTH_MAX) begin : g_bad_width
    $error("gen_cla_pipelined: WIDTH out of range");
  end

  // ---------------- handshake ----------------
  logic s1_valid;
  logic s2_valid;
  logic s2_load;
  logic can_accept;

  // in_ready is a function of pipeline state and out_ready only.
  assign s2_load    = s1_valid & (~s2_valid | bus.out_ready);
  assign can_accept = ~rst & (~s1_valid | s2_load);
  assign bus.in_ready = can_accept;

  // ---------------- stage 1: split ----------------
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic             c0_eff;

  always_comb begin
    is_sub = (bus.mode == CLA_SUB);
    b_eff  = is_sub ? ~bus.b : bus.b;
    c0_eff = is_sub ? 1'b1 : bus.cin;
  end

  logic [WIDTH-1:0] s1_g;
  logic [WIDTH-1:0] s1_p;
  logic             s1_c0;
  logic             s1_a_msb;
  logic             s1_b_msb;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_c0    <= 1'b0;
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
    end else if (can_accept) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_g     <= bus.a & b_eff;
        s1_p     <= bus.a ^ b_eff;
        s1_c0    <= c0_eff;
        s1_a_msb <= bus.a[WIDTH-1];
        s1_b_msb <= b_eff[WIDTH-1];
      end
    end
  end

  // ---------------- stage 2: lookahead ----------------
  // Bits above WIDTH in a partial last group are padded with p=1, g=0 so
  // that group's G/P describe the real bits alone and still yield cout.
  logic [PW-1:0] g_pad;
  logic [PW-1:0] p_pad;

  always_comb begin
    g_pad = '0;
    p_pad = '1;
    g_pad[WIDTH-1:0] = s1_g;
    p_pad[WIDTH-1:0] = s1_p;
  end

  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_p;
  logic [NG-1:0] grp_c;
  logic [PW-1:0] c_bits;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_carry_group #(
      .GROUP (GROUP)
    ) u_grp (
      .g     (g_pad[gi*GROUP +: GROUP]),
      .p     (p_pad[gi*GROUP +: GROUP]),
      .c_in  (grp_c[gi]),
      .c     (c_bits[gi*GROUP +: GROUP]),
      .grp_g (grp_g[gi]),
      .grp_p (grp_p[gi])
    );
  end

  // Inter-group carries, flattened over group G/P and the stage-1 carry.
  logic lk_term;
  logic lk_acc;

  always_comb begin
    grp_c    = '0;
    lk_term  = 1'b0;
    lk_acc   = 1'b0;
    grp_c[0] = s1_c0;
    for (int unsigned i = 1; i < NG; i++) begin
      lk_term = s1_c0;
      for (int unsigned j = 0; j < i; j++) begin
        lk_term = lk_term & grp_p[j];
      end
      lk_acc = lk_term;
      for (int unsigned j = 0; j < i; j++) begin
        lk_term = grp_g[j];
        for (int unsigned k = j + 1; k < i; k++) begin
          lk_term = lk_term & grp_p[k];
        end
        lk_acc = lk_acc | lk_term;
      end
      grp_c[i] = lk_acc;
    end
  end

  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;

  // Overflow when operands agree in sign and the sum does not; this is the
  // same as carry-into-MSB XOR cout.
  always_comb begin
    sum_c  = s1_p ^ c_bits[WIDTH-1:0];
    cout_c = grp_g[NG-1] | (grp_p[NG-1] & grp_c[NG-1]);
    ovf_c  = ~(s1_a_msb ^ s1_b_msb) & (s1_a_msb ^ sum_c[WIDTH-1]);
  end

  logic [WIDTH-1:0] s2_s;
  logic             s2_cout;
  logic             s2_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_s     <= '0;
      s2_cout  <= 1'b0;
      s2_ovf   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_s     <= sum_c;
      s2_cout  <= cout_c;
      s2_ovf   <= ovf_c;
    end else if (bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.s         = s2_s;
  assign bus.cout      = s2_cout;
  assign bus.ovf       = s2_ovf;

endmodule
